// File: rtl/kovacs_state_accumulator_pkg.sv
// Shared constants and types for the Kovacs state accumulator: default widths,
// protocol indicator encoding and the segment-state / arming enums.
package kovacs_state_accumulator_pkg;

   localparam int SUM_W_DEF   = 48;
   localparam int CNT_W_DEF   = 32;
   localparam int BLANK_W_DEF = 16;
   localparam int DATA_W      = 14;
   localparam int IDX_W       = 32;

   localparam logic [DATA_W-1:0] IND_STATE0 = 14'd8191;
   localparam logic [DATA_W-1:0] IND_STATE1 = 14'd0;

   typedef enum logic {
      STATE0 = 1'b0,
      STATE1 = 1'b1
   } protoState_e;

   typedef enum logic {
      ARM_IDLE = 1'b0,
      ARM_ON   = 1'b1
   } armState_e;

   // Any nonzero indicator means the original potential (state 0).
   function automatic protoState_e indToState(input logic [DATA_W-1:0] ind);
      return (ind == IND_STATE1) ? STATE1 : STATE0;
   endfunction

endpackage

// File: rtl/kovacs_state_accumulator_if.sv
// Sample-in / result-out bundle between the protocol stage, the accumulator
// and the PS readout path.
interface kovacs_state_accumulator_if
   import kovacs_state_accumulator_pkg::*;
#(
   parameter int SUM_W   = SUM_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BLANK_W = BLANK_W_DEF
);
   logic                     enable_i;
   logic signed [DATA_W-1:0] data_i;
   logic [DATA_W-1:0]        indicator_i;
   logic [BLANK_W-1:0]       blank_i;

   logic signed [SUM_W-1:0]  sum_o;
   logic [CNT_W-1:0]         count_o;
   logic                     seg_state_o;
   logic [IDX_W-1:0]         seg_index_o;
   logic                     valid_o;
   logic                     ovf_o;

   modport master (
      output enable_i, data_i, indicator_i, blank_i,
      input  sum_o, count_o, seg_state_o, seg_index_o, valid_o, ovf_o
   );

   modport slave (
      input  enable_i, data_i, indicator_i, blank_i,
      output sum_o, count_o, seg_state_o, seg_index_o, valid_o, ovf_o
   );
endinterface

// File: rtl/kovacs_seg_accum.sv
// Per-segment settling blank counter and saturating signed accumulator.
// A load starts a new segment and treats the same-cycle sample with the new blank.
module kovacs_seg_accum
   import kovacs_state_accumulator_pkg::*;
#(
   parameter int SUM_W   = SUM_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BLANK_W = BLANK_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     i_clear,
   input  logic                     i_load,
   input  logic [BLANK_W-1:0]       i_blank,
   input  logic signed [DATA_W-1:0] i_sample,
   output logic signed [SUM_W-1:0]  o_sum,
   output logic [CNT_W-1:0]         o_count,
   output logic                     o_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [BLANK_W-1:0]      r_blankCnt;
   logic signed [SUM_W-1:0] r_sum;
   logic [CNT_W-1:0]        r_count;
   logic signed [SUM_W-1:0] w_sampleExt;

   assign w_sampleExt = {{(SUM_W-DATA_W){i_sample[DATA_W-1]}}, i_sample};

   // Once the count saturates both sum and count freeze until the next load.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_blankCnt <= '0;
         r_sum      <= '0;
         r_count    <= '0;
      end else if (i_clear) begin
         r_blankCnt <= '0;
         r_sum      <= '0;
         r_count    <= '0;
      end else if (i_load) begin
         if (i_blank != '0) begin
            r_blankCnt <= i_blank - BLANK_W'(1);
            r_sum      <= '0;
            r_count    <= '0;
         end else begin
            r_blankCnt <= '0;
            r_sum      <= w_sampleExt;
            r_count    <= CNT_W'(1);
         end
      end else if (r_blankCnt != '0) begin
         r_blankCnt <= r_blankCnt - BLANK_W'(1);
      end else if (r_count != CNT_MAX) begin
         r_sum   <= r_sum + w_sampleExt;
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_sum   = r_sum;
   assign o_count = r_count;
   assign o_ovf   = (r_count == CNT_MAX);

endmodule

// File: rtl/kovacs_state_accumulator.sv
// Segments the protocol stream at state changes and reports sum/count per
// completed half-period; the first segment after reset or enable is discarded.
module kovacs_state_accumulator
   import kovacs_state_accumulator_pkg::*;
#(
   parameter int SUM_W   = SUM_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BLANK_W = BLANK_W_DEF
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   kovacs_state_accumulator_if.slave  bus
);

   logic                     r_enQ;
   logic [DATA_W-1:0]        r_indQ;
   logic signed [DATA_W-1:0] r_dataQ;
   protoState_e              r_prevState;
   protoState_e              w_curState;
   armState_e                r_armState;
   armState_e                w_armNext;
   logic                     w_edge;
   logic                     w_report;
   logic                     w_clear;

   logic signed [SUM_W-1:0]  w_accSum;
   logic [CNT_W-1:0]         w_accCnt;
   logic                     w_accOvf;

   logic signed [SUM_W-1:0]  r_sum;
   logic [CNT_W-1:0]         r_count;
   logic                     r_segState;
   logic [IDX_W-1:0]         r_segIndex;
   logic                     r_valid;
   logic                     r_ovf;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_enQ       <= 1'b0;
         r_indQ      <= '0;
         r_dataQ     <= '0;
         r_prevState <= STATE0;
      end else begin
         r_enQ       <= bus.enable_i;
         r_indQ      <= bus.indicator_i;
         r_dataQ     <= bus.data_i;
         r_prevState <= w_curState;
      end
   end

   assign w_curState = indToState(r_indQ);
   assign w_edge     = r_enQ && (w_curState != r_prevState);
   assign w_report   = w_edge && (r_armState == ARM_ON);
   assign w_clear    = ~r_enQ;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_armState <= ARM_IDLE;
      end else begin
         r_armState <= w_armNext;
      end
   end

   // Any edge while enabled arms; losing enable disarms so the next segment is partial.
   always_comb begin
      w_armNext = r_armState;
      if (!r_enQ) begin
         w_armNext = ARM_IDLE;
      end else if (w_edge) begin
         w_armNext = ARM_ON;
      end
   end

   kovacs_seg_accum #(
      .SUM_W   (SUM_W),
      .CNT_W   (CNT_W),
      .BLANK_W (BLANK_W)
   ) u_segAccum (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .i_clear  (w_clear),
      .i_load   (w_edge),
      .i_blank  (bus.blank_i),
      .i_sample (r_dataQ),
      .o_sum    (w_accSum),
      .o_count  (w_accCnt),
      .o_ovf    (w_accOvf)
   );

   // The accumulator still holds the finished segment during the edge cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_sum      <= '0;
         r_count    <= '0;
         r_segState <= 1'b0;
         r_segIndex <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_valid <= w_report;
         if (w_report) begin
            r_sum      <= w_accSum;
            r_count    <= w_accCnt;
            r_ovf      <= w_accOvf;
            r_segState <= r_prevState;
            r_segIndex <= r_segIndex + IDX_W'(1);
         end
      end
   end

   assign bus.sum_o       = r_sum;
   assign bus.count_o     = r_count;
   assign bus.seg_state_o = r_segState;
   assign bus.seg_index_o = r_segIndex;
   assign bus.valid_o     = r_valid;
   assign bus.ovf_o       = r_ovf;

endmodule

// File: tb/tb_kovacs_state_accumulator.sv
// Bench for kovacs_state_accumulator: a default build and a CNT_W=4 build share
// stimulus and are compared each cycle against a segment-level reference model.
module tb_kovacs_state_accumulator;
   import kovacs_state_accumulator_pkg::*;

   localparam int     SUM_W   = 48;
   localparam int     CNT_A   = 32;
   localparam int     CNT_S   = 4;
   localparam int     BLANK_W = 16;
   localparam longint MAX_A   = 64'd4294967295;
   localparam longint MAX_S   = 64'd15;

   logic                     clk = 1'b0;
   logic                     rstn = 1'b0;
   logic                     enable = 1'b0;
   logic signed [DATA_W-1:0] data = '0;
   logic [DATA_W-1:0]        indicator = IND_STATE1;
   logic [BLANK_W-1:0]       blank = '0;
   bit                       curSt = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   kovacs_state_accumulator_if #(.SUM_W(SUM_W), .CNT_W(CNT_A), .BLANK_W(BLANK_W)) busA ();
   kovacs_state_accumulator_if #(.SUM_W(SUM_W), .CNT_W(CNT_S), .BLANK_W(BLANK_W)) busS ();

   assign busA.enable_i    = enable;
   assign busA.data_i      = data;
   assign busA.indicator_i = indicator;
   assign busA.blank_i     = blank;
   assign busS.enable_i    = enable;
   assign busS.data_i      = data;
   assign busS.indicator_i = indicator;
   assign busS.blank_i     = blank;

   kovacs_state_accumulator #(.SUM_W(SUM_W), .CNT_W(CNT_A), .BLANK_W(BLANK_W)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (busA)
   );

   kovacs_state_accumulator #(.SUM_W(SUM_W), .CNT_W(CNT_S), .BLANK_W(BLANK_W)) dutSat (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (busS)
   );

   // Reference model: remembers every sample of the current segment and derives
   // the result from the list when the segment ends.
   bit          mEnQ = 1'b0;
   logic [13:0] mIndQ = '0;
   int          mDataQ = 0;
   bit          mPrev = 1'b0;
   bit          mArmed = 1'b0;
   int          mBlankStart = 0;
   int          q[$];

   bit          eValid = 1'b0;
   bit          eState = 1'b0;
   bit          eOvfA = 1'b0;
   bit          eOvfS = 1'b0;
   longint      eSumA = 0;
   longint      eSumS = 0;
   longint      eCntA = 0;
   longint      eCntS = 0;
   int unsigned eIdx = 0;

   wire [114:0] gotA = {busA.valid_o, busA.sum_o, busA.count_o, busA.seg_state_o, busA.seg_index_o, busA.ovf_o};
   wire [86:0]  gotS = {busS.valid_o, busS.sum_o, busS.count_o, busS.seg_state_o, busS.seg_index_o, busS.ovf_o};
   wire [114:0] expA = {eValid, eSumA[SUM_W-1:0], eCntA[CNT_A-1:0], eState, eIdx, eOvfA};
   wire [86:0]  expS = {eValid, eSumS[SUM_W-1:0], eCntS[CNT_S-1:0], eState, eIdx, eOvfS};

   function automatic void segResult(input longint maxCnt, output longint sum, output longint cnt, output bit ovf);
      longint avail;
      avail = longint'(q.size()) - longint'(mBlankStart);
      if (avail < 0) avail = 0;
      cnt = (avail > maxCnt) ? maxCnt : avail;
      sum = 0;
      for (int i = 0; i < int'(cnt); i++) sum += longint'(q[mBlankStart + i]);
      ovf = (cnt == maxCnt);
   endfunction

   always @(posedge clk or negedge rstn) begin : model
      bit cur;
      if (!rstn) begin
         mEnQ = 0; mIndQ = '0; mDataQ = 0; mPrev = 0; mArmed = 0; mBlankStart = 0;
         q.delete();
         eValid = 0; eState = 0; eOvfA = 0; eOvfS = 0;
         eSumA = 0; eSumS = 0; eCntA = 0; eCntS = 0; eIdx = 0;
      end else begin
         cur    = (mIndQ == 14'd0);
         eValid = 0;
         if (mEnQ) begin
            if (cur != mPrev) begin
               if (mArmed) begin
                  segResult(MAX_A, eSumA, eCntA, eOvfA);
                  segResult(MAX_S, eSumS, eCntS, eOvfS);
                  eState = mPrev;
                  eIdx++;
                  eValid = 1;
               end
               q.delete();
               mBlankStart = int'(blank);
               mArmed = 1;
            end
            q.push_back(mDataQ);
         end else begin
            q.delete();
            mArmed = 0;
         end
         mPrev  = cur;
         mEnQ   = enable;
         mIndQ  = indicator;
         mDataQ = int'(data);
      end
   end

   task automatic setIn(input bit en, input int d, input int b);
      enable    = en;
      data      = 14'(d);
      indicator = curSt ? IND_STATE1 : IND_STATE0;
      blank     = BLANK_W'(b);
   endtask

   task automatic preamble();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         setIn(1'b0, 0, 0);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      setIn(1'b0, 100, 0);
      repeat (3) @(negedge clk);
      checks += 2;
      if (gotA !== '0) begin errors++; $display("[TB] FAIL reset_a got=%h exp=0", gotA); end
      if (gotS !== '0) begin errors++; $display("[TB] FAIL reset_s got=%h exp=0", gotS); end
      rstn = 1'b1;
   endtask

   task automatic test_constant();
      preamble();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         checks += 3;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL const_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL const_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (busA.valid_o !== (c >= 17 && (c - 17) % 10 == 0))
            begin errors++; $display("[TB] FAIL const_latency c=%0d valid=%0b", c, busA.valid_o); end
         if (busA.valid_o) begin
            checks++;
            if (busA.count_o !== 10 || busA.sum_o !== 50)
               begin errors++; $display("[TB] FAIL const_value count=%0d sum=%0d exp 10/50", busA.count_o, busA.sum_o); end
         end
         if (c % 10 == 5) curSt = ~curSt;
         setIn(1'b1, 5, 0);
      end
   endtask

   task automatic test_signed_blank();
      preamble();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         checks += 2;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL sblank_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL sblank_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (busA.valid_o) begin
            checks++;
            if (busA.count_o !== 7 || busA.sum_o !== -14)
               begin errors++; $display("[TB] FAIL sblank_value count=%0d sum=%0d exp 7/-14", busA.count_o, busA.sum_o); end
         end
         if (c % 10 == 5) curSt = ~curSt;
         setIn(1'b1, -2, 3);
      end
   endtask

   task automatic test_blank_ge_length();
      int nValid = 0;
      preamble();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         checks += 2;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL bigblank_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL bigblank_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (busA.valid_o) begin
            nValid++;
            checks++;
            if (busA.count_o !== 0 || busA.sum_o !== 0)
               begin errors++; $display("[TB] FAIL bigblank_value count=%0d sum=%0d exp 0/0", busA.count_o, busA.sum_o); end
         end
         if (c % 10 == 5) curSt = ~curSt;
         setIn(1'b1, 9, 20);
      end
      checks++;
      if (nValid != 4) begin errors++; $display("[TB] FAIL bigblank_pulses got=%0d exp=4", nValid); end
   endtask

   task automatic test_saturation();
      int nS = 0;
      preamble();
      for (int c = 0; c < 58; c++) begin
         @(negedge clk);
         checks += 2;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL sat_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL sat_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (busS.valid_o) begin
            nS++;
            checks++;
            if (busS.count_o !== ((nS <= 2) ? 4'd15 : 4'd10) || busS.sum_o !== ((nS <= 2) ? 15 : 10) || busS.ovf_o !== (nS <= 2))
               begin errors++; $display("[TB] FAIL sat_value n=%0d count=%0d sum=%0d ovf=%0b", nS, busS.count_o, busS.sum_o, busS.ovf_o); end
         end
         if (c == 3 || c == 23 || c == 43 || c == 53) curSt = ~curSt;
         setIn(1'b1, 1, 0);
      end
      checks++;
      if (nS != 3) begin errors++; $display("[TB] FAIL sat_pulses got=%0d exp=3", nS); end
   endtask

   task automatic test_enable_drop();
      int nValid = 0;
      preamble();
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         checks += 2;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL endrop_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL endrop_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (busA.valid_o) begin
            nValid++;
            checks++;
            if (busA.count_o !== 10 || busA.sum_o !== 70)
               begin errors++; $display("[TB] FAIL endrop_value count=%0d sum=%0d exp 10/70", busA.count_o, busA.sum_o); end
         end
         if (c % 10 == 5) curSt = ~curSt;
         setIn(!(c >= 18 && c <= 22), 7, 0);
      end
      checks++;
      if (nValid != 4) begin errors++; $display("[TB] FAIL endrop_pulses got=%0d exp=4", nValid); end
   endtask

   task automatic test_back_to_back();
      preamble();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks += 2;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL b2b_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL b2b_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (c == 8 || c == 9) begin
            checks++;
            if (busA.valid_o !== 1'b1 || busA.count_o !== 1)
               begin errors++; $display("[TB] FAIL b2b_single c=%0d valid=%0b count=%0d exp 1/1", c, busA.valid_o, busA.count_o); end
         end
         if (c == 5 || c == 6 || c == 7 || c == 15) curSt = ~curSt;
         setIn(1'b1, c + 1, 0);
      end
   endtask

   task automatic test_random();
      int offLeft = 0;
      int bl = 0;
      preamble();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         checks += 2;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL rand_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL rand_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if ($urandom_range(0, 5) == 0) curSt = ~curSt;
         if ($urandom_range(0, 19) == 0) bl = int'($urandom_range(0, 4));
         if (offLeft > 0) offLeft--;
         else if ($urandom_range(0, 59) == 0) offLeft = int'($urandom_range(1, 6));
         setIn(offLeft == 0, int'($urandom_range(0, 16383)), bl);
      end
   endtask

   task automatic test_reset_mid();
      int edges = 0;
      preamble();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks += 2;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL rmid_pre_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL rmid_pre_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (c == 3 || c == 11 || c == 17) curSt = ~curSt;
         setIn(1'b1, 100, 0);
      end
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks += 2;
      if (gotA !== '0) begin errors++; $display("[TB] FAIL rmid_async_a got=%h exp=0", gotA); end
      if (gotS !== '0) begin errors++; $display("[TB] FAIL rmid_async_s got=%h exp=0", gotS); end
      setIn(1'b0, 100, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      preamble();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         checks += 3;
         if (gotA !== expA) begin errors++; $display("[TB] FAIL rmid_post_a c=%0d got=%h exp=%h", c, gotA, expA); end
         if (gotS !== expS) begin errors++; $display("[TB] FAIL rmid_post_s c=%0d got=%h exp=%h", c, gotS, expS); end
         if (edges < 2 && busA.valid_o !== 1'b0)
            begin errors++; $display("[TB] FAIL rmid_early_valid c=%0d valid=%0b exp=0", c, busA.valid_o); end
         if (c == 4 || c == 12 || c == 20) begin curSt = ~curSt; edges++; end
         setIn(1'b1, 100, 0);
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_signed_blank();
      test_blank_ge_length();
      test_saturation();
      test_enable_drop();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
